aes_encryption_slave: RTL and testbench



---
 rtl/aes_encryption_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_aes_encryption_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encryption_slave.sv
// Serial-in/serial-out AES encryption slave (AES-128/192/256 selected by NK/NR).
// Define AES_SLAVE_MISO_TRISTATE_EN to float miso whenever cs is high.
module aes_encryption_slave #(
  parameter int unsigned NK       = 4,
  parameter int unsigned NR       = 10,
  parameter int unsigned RESP_GAP = 56
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic mosi,
  output logic miso
);

  localparam int unsigned KEY_BITS = NK * 32;
  localparam int unsigned NW       = 4 * (NR + 1);
  localparam int unsigned AW       = $clog2(NW);
  localparam int unsigned WW       = $clog2(NW + 1);
  localparam int unsigned RW       = $clog2(NR + 1);
  localparam int unsigned GW       = $clog2(RESP_GAP + 1);
  localparam int unsigned BW       = 9;

  typedef enum logic [2:0] {IDLE, KEY, PT, CALC, GAP, SEND} state_t;

  state_t              st_q;
  logic [BW-1:0]       bit_cnt;
  logic [KEY_BITS-2:0] key_sr;
  logic [31:0]         w [NW];
  logic [WW-1:0]       ki;
  logic [2:0]          kmod;
  logic [7:0]          rcon;
  logic [RW-1:0]       rnd;
  logic [GW-1:0]       gap_cnt;
  logic [127:0]        blk;
  logic [127:0]        out_sr;
  logic                miso_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 by square-and-multiply, then the FIPS affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31-8*i -: 8] = sbox(x[31-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      m[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return m;
  endfunction

  logic [KEY_BITS-1:0] key_c;
  logic [31:0]         kw_prev, kw_tmp, w_next;
  logic [AW-1:0]       rk_base;
  logic [127:0]        rk, sr_c, rnd_c;

  assign key_c = {key_sr, mosi};

  // Next expanded key word; the extra SubWord applies only to 256-bit keys (FIPS-197).
  always_comb begin
    kw_prev = w[AW'(ki - WW'(1))];
    kw_tmp  = kw_prev;
    if (kmod == 3'd0)
      kw_tmp = sub_word({kw_prev[23:0], kw_prev[31:24]}) ^ {rcon, 24'h000000};
    else if (NK > 6 && kmod == 3'd4)
      kw_tmp = sub_word(kw_prev);
    w_next = w[AW'(ki - WW'(NK))] ^ kw_tmp;
  end

  // One cipher round per clock; round 0 is the initial AddRoundKey.
  always_comb begin
    rk_base = AW'({rnd, 2'b00});
    rk      = {w[rk_base], w[rk_base + AW'(1)], w[rk_base + AW'(2)], w[rk_base + AW'(3)]};
    sr_c    = shift_rows(sub_bytes(blk));
    if (rnd == '0)
      rnd_c = blk ^ rk;
    else if (rnd == RW'(NR))
      rnd_c = sr_c ^ rk;
    else
      rnd_c = mix_columns(sr_c) ^ rk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      bit_cnt <= '0;
      key_sr  <= '0;
      ki      <= '0;
      kmod    <= '0;
      rcon    <= '0;
      rnd     <= '0;
      gap_cnt <= '0;
      blk     <= '0;
      out_sr  <= '0;
      miso_q  <= 1'b0;
      for (int i = 0; i < int'(NW); i++) w[i] <= '0;
    end else if (cs) begin
      st_q    <= IDLE;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          key_sr  <= key_c[KEY_BITS-2:0];
          bit_cnt <= BW'(1);
          st_q    <= KEY;
        end
        KEY: begin
          key_sr <= key_c[KEY_BITS-2:0];
          if (bit_cnt == BW'(KEY_BITS - 1)) begin
            for (int j = 0; j < int'(NK); j++) w[j] <= key_c[KEY_BITS-1-32*j -: 32];
            bit_cnt <= '0;
            ki      <= WW'(NK);
            kmod    <= '0;
            rcon    <= 8'h01;
            st_q    <= PT;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PT: begin
          blk <= {blk[126:0], mosi};
          if (ki < WW'(NW)) begin
            w[AW'(ki)] <= w_next;
            ki         <= ki + WW'(1);
            kmod       <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xtime(rcon);
          end
          if (bit_cnt == BW'(127)) begin
            bit_cnt <= '0;
            rnd     <= '0;
            gap_cnt <= GW'(1);
            st_q    <= CALC;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        CALC: begin
          blk     <= rnd_c;
          gap_cnt <= gap_cnt + GW'(1);
          if (rnd == RW'(NR)) begin
            out_sr <= rnd_c;
            st_q   <= GAP;
          end else begin
            rnd <= rnd + RW'(1);
          end
        end
        GAP: begin
          // gap_cnt tracks clocks since the last plaintext bit.
          if (gap_cnt == GW'(RESP_GAP)) begin
            miso_q  <= out_sr[127];
            out_sr  <= {out_sr[126:0], 1'b0};
            bit_cnt <= BW'(1);
            st_q    <= SEND;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        SEND: begin
          if (bit_cnt == BW'(128)) begin
            miso_q  <= 1'b0;
            bit_cnt <= '0;
            st_q    <= IDLE;
          end else begin
            miso_q  <= out_sr[127];
            out_sr  <= {out_sr[126:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

`ifdef AES_SLAVE_MISO_TRISTATE_EN
  assign miso = cs ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_aes_encryption_slave.sv
// Bench for aes_encryption_slave: AES-128/192/256 instances on a shared mosi,
// checked against FIPS-197 vectors and a byte-level reference model.
module tb_aes_encryption_slave;

  localparam int GAP = 56;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic       clk = 1'b0;
  logic       reset;
  logic       mosi;
  logic [2:0] csv;
  logic [2:0] miso_v;
  int         total = 0;
  int         bad = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_encryption_slave #(.NK(4), .NR(10), .RESP_GAP(GAP)) u_aes128 (
    .clk(clk), .reset(reset), .cs(csv[0]), .mosi(mosi), .miso(miso_v[0]));
  aes_encryption_slave #(.NK(6), .NR(12), .RESP_GAP(GAP)) u_aes192 (
    .clk(clk), .reset(reset), .cs(csv[1]), .mosi(mosi), .miso(miso_v[1]));
  aes_encryption_slave #(.NK(8), .NR(14), .RESP_GAP(GAP)) u_aes256 (
    .clk(clk), .reset(reset), .cs(csv[2]), .mosi(mosi), .miso(miso_v[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return 8'({a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00));
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box by brute-force inverse search.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input int nk, input logic [255:0] key,
                                           input logic [127:0] pt);
    int         nr;
    logic [7:0] wb [240];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, hold, a0, a1, a2, a3;
    logic [127:0] res;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * nk; i++) wb[i] = key[nk*32-1-8*i -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = wb[4*(i-1)+j];
      if (i % nk == 0) begin
        hold   = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[hold];
        rc     = m_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_t[tmp[j]];
      end
      for (int j = 0; j < 4; j++) wb[4*i+j] = wb[4*(i-nk)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ wb[i];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != nr) begin
          s[4*c]   = m_mul(8'h02, a0) ^ m_mul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(8'h02, a1) ^ m_mul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(8'h02, a2) ^ m_mul(8'h03, a3);
          s[4*c+3] = m_mul(8'h03, a0) ^ a1 ^ a2 ^ m_mul(8'h02, a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ wb[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- serial master ----------------
  task automatic shift_in(input int sel, input int nk, input logic [255:0] key,
                          input logic [127:0] pt);
    csv[2'(sel)] = 1'b0;
    for (int i = 0; i < nk * 32; i++) begin
      mosi = key[8'(nk*32-1-i)];
      @(negedge clk);
    end
    for (int i = 0; i < 128; i++) begin
      mosi = pt[7'(127-i)];
      @(negedge clk);
    end
  endtask

  // Samples miso on falling edges; quiet drops if miso is non-zero outside the data window.
  task automatic collect(input int sel, output logic [127:0] ct, output logic quiet);
    quiet = 1'b1;
    ct    = '0;
    for (int k = 1; k <= GAP + 128; k++) begin
      mosi = 1'($urandom);
      @(negedge clk);
      if (k >= GAP && k < GAP + 128) ct[7'(127-(k-GAP))] = miso_v[2'(sel)];
      else if (miso_v[2'(sel)] !== 1'b0) quiet = 1'b0;
    end
  endtask

  task automatic run_txn(input int sel, input int nk, input logic [255:0] key,
                         input logic [127:0] pt, output logic [127:0] ct,
                         output logic quiet);
    shift_in(sel, nk, key, pt);
    collect(sel, ct, quiet);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    csv   = 3'b111;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (miso_v[2'(i)] !== 1'b0) begin
        bad++;
        $display("FAIL reset_miso[%0d] got=%b exp=0", i, miso_v[2'(i)]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector(input int sel, input int nk, input logic [255:0] key,
                             input logic [127:0] exp, input string nm);
    logic [127:0] ct;
    logic         quiet;
    run_txn(sel, nk, key, PT0, ct, quiet);
    csv[2'(sel)] = 1'b1;
    total++;
    if (ct !== exp) begin
      bad++;
      $display("FAIL %s ct got=%h exp=%h", nm, ct, exp);
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL %s miso_idle got=%b exp=1", nm, quiet);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt, ct, exp;
    logic         quiet;
    int           sel, nk;
    for (int n = 0; n < 6; n++) begin
      sel = n % 3;
      nk  = 4 + 2 * sel;
      key = rand_key();
      pt  = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_aes(nk, key, pt);
      run_txn(sel, nk, key, pt, ct, quiet);
      csv[2'(sel)] = 1'b1;
      total++;
      if (ct !== exp || quiet !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d] nk=%0d ct got=%h exp=%h quiet=%b", n, nk, ct, exp, quiet);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic ok;
    // Abort part-way through the key.
    csv[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      mosi = 1'($urandom);
      @(negedge clk);
    end
    csv[0] = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      mosi = 1'($urandom);
      @(negedge clk);
      if (miso_v[0] !== 1'b0) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL abort_key miso got_nonzero=%b exp=0", !ok);
    end
    test_vector(0, 4, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "abort_key_restart");
    // Abort during the response gap: nothing may come out.
    shift_in(2, 8, rand_key(), PT0);
    repeat (20) @(negedge clk);
    csv[2] = 1'b1;
    ok = 1'b1;
    repeat (GAP + 140) begin
      mosi = 1'($urandom);
      @(negedge clk);
      if (miso_v[2] !== 1'b0) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL abort_gap miso got_nonzero=%b exp=0", !ok);
    end
    test_vector(2, 8, K256, 128'h8ea2b7ca516745bfeafc49904b496089, "abort_gap_restart");
  endtask

  task automatic test_reset_send();
    logic [255:0] key;
    logic [127:0] pt, exp, ct;
    logic [39:0]  part;
    logic         quiet;
    key = rand_key();
    pt  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_aes(6, key, pt);
    shift_in(1, 6, key, pt);
    part = '0;
    for (int k = 1; k < GAP + 40; k++) begin
      mosi = 1'($urandom);
      @(negedge clk);
      if (k >= GAP) part[6'(39-(k-GAP))] = miso_v[1];
    end
    total++;
    if (part !== exp[127:88]) begin
      bad++;
      $display("FAIL rst_send_prefix got=%h exp=%h", part, exp[127:88]);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (miso_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_send_miso got=%b exp=0", miso_v[1]);
    end
    reset  = 1'b0;
    csv[1] = 1'b1;
    @(negedge clk);
    key = rand_key();
    pt  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_aes(6, key, pt);
    run_txn(1, 6, key, pt, ct, quiet);
    csv[1] = 1'b1;
    total++;
    if (ct !== exp || quiet !== 1'b1) begin
      bad++;
      $display("FAIL rst_send_after ct got=%h exp=%h quiet=%b", ct, exp, quiet);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt2, ct1, ct2, exp2;
    logic         q1, q2;
    pt2  = {$urandom, $urandom, $urandom, $urandom};
    exp2 = ref_aes(8, K256, pt2);
    run_txn(2, 8, K256, PT0, ct1, q1);
    run_txn(2, 8, K256, pt2, ct2, q2);
    csv[2] = 1'b1;
    total++;
    if (ct1 !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
      bad++;
      $display("FAIL b2b_first got=%h exp=8ea2b7ca516745bfeafc49904b496089", ct1);
    end
    total++;
    if (ct2 !== exp2) begin
      bad++;
      $display("FAIL b2b_second got=%h exp=%h", ct2, exp2);
    end
    total++;
    if (q1 !== 1'b1 || q2 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_miso_idle got=%b%b exp=11", q1, q2);
    end
    @(negedge clk);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vector(0, 4, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "aes128");
    test_vector(1, 6, K192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "aes192");
    test_vector(2, 8, K256, 128'h8ea2b7ca516745bfeafc49904b496089, "aes256");
    test_random();
    test_abort();
    test_reset_send();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
